// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches, and buffers
// in-order responses with their PCs for decode. Redirects flush and drop stale responses.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    logic [31:0] pc_q, pc_d;
    cnt_t        outst_q, outst_d;
    cnt_t        drop_q, drop_d;

    logic [31:0] fifo_data_q [FIFO_DEPTH];
    logic [31:0] fifo_pc_q   [FIFO_DEPTH];
    ptr_t        fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
    cnt_t        fifo_cnt_q, fifo_cnt_d;

    logic [31:0] pcq_q [FIFO_DEPTH];
    ptr_t        pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;

    logic        req_fire, rsp_take, push, pop;
    logic [CW:0] credit_used;
    logic [1:0]  unused_redirect_lsb;

    assign unused_redirect_lsb = redirect_pc[1:0];

    // Outstanding requests plus buffered entries never exceed the FIFO size,
    // so every accepted response is guaranteed a slot.
    assign credit_used    = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
    assign imem_req_valid = !rst && (credit_used < DEPTH_C) && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_take = imem_rsp_valid && (outst_q != '0);
    assign push     = rsp_take && !redirect_valid && (drop_q == '0);
    assign pop      = instr_valid && instr_ready && !redirect_valid;

    assign instr_valid = (fifo_cnt_q != '0);
    assign instr       = fifo_data_q[fifo_rd_q];
    assign instr_pc    = fifo_pc_q[fifo_rd_q];

    always_comb begin
        pc_d       = pc_q;
        drop_d     = drop_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_wr_d  = fifo_wr_q;
        pcq_rd_d   = pcq_rd_q;
        pcq_wr_d   = pcq_wr_q;
        outst_d    = outst_q + cnt_t'(req_fire) - cnt_t'(rsp_take);
        fifo_cnt_d = fifo_cnt_q + cnt_t'(push) - cnt_t'(pop);
        if (req_fire) begin
            pc_d     = pc_q + 32'd4;
            pcq_wr_d = pcq_wr_q + 1'b1;
        end
        if (push) begin
            pcq_rd_d  = pcq_rd_q + 1'b1;
            fifo_wr_d = fifo_wr_q + 1'b1;
        end
        if (pop) begin
            fifo_rd_d = fifo_rd_q + 1'b1;
        end
        if (rsp_take && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end
        // Every response still owed after this cycle belongs to the old stream.
        if (redirect_valid) begin
            pc_d       = {redirect_pc[31:2], 2'b00};
            drop_d     = outst_d;
            fifo_rd_d  = '0;
            fifo_wr_d  = '0;
            fifo_cnt_d = '0;
            pcq_rd_d   = '0;
            pcq_wr_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            fifo_cnt_q <= '0;
            pcq_rd_q   <= '0;
            pcq_wr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_cnt_q <= fifo_cnt_d;
            pcq_rd_q   <= pcq_rd_d;
            pcq_wr_q   <= pcq_wr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
                pcq_q[i]       <= '0;
            end
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (push && (fifo_wr_q == ptr_t'(i))) begin
                    fifo_data_q[i] <= imem_rsp_data;
                    fifo_pc_q[i]   <= pcq_q[pcq_rd_q];
                end
                if (req_fire && (pcq_wr_q == ptr_t'(i))) begin
                    pcq_q[i] <= pc_q;
                end
            end
        end
    end

    a_rsp_with_credit: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outst_q != '0));
    a_outst_bound: assert property (@(posedge clk) disable iff (rst)
        (outst_q <= cnt_t'(FIFO_DEPTH)) && (drop_q <= outst_q));

endmodule
